vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port video RAM between the display fetch path (VDG data counter / preload strobe) and the host CPU.
- Display fetches are high priority and in-order, buffered in a small FIFO.
- The CPU is guaranteed a slot after at most VID_RUN_MAX consecutive video accesses.
- Sits between the frame/data-address logic and the RAM, and returns fetched bytes to the video data shift register.

Parameters:
ADDR_W, 13, RAM address width (matches DA width)
VID_RUN_MAX, 4, consecutive video issues allowed while CPU eligible before CPU forced a slot
VID_FIFO_DEPTH, 2, pending video request entries (>=1)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
vid_req  in  1  one-cycle fetch request from display path; may assert every cycle
vid_addr  in  ADDR_W  fetch address, sampled with vid_req
vid_valid  out  1  one-cycle pulse: vid_data holds fetched byte
vid_data  out  8  fetched byte (wire from mem_rdata, meaningful only with vid_valid)
vid_overrun  out  1  sticky: a video request was dropped
vid_overrun_clr  in  1  clears vid_overrun
cpu_req  in  1  level request, held until cpu_ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  8  write data
cpu_ack  out  1  one-cycle pulse: access complete; cpu_rdata valid for reads
cpu_rdata  out  8  read byte (wire from mem_rdata)
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  8  RAM write data
mem_rdata  in  8  RAM read data, valid cycle after mem_en with mem_we=0

Behaviour:
- Reset: at the first edge with reset=1, all outputs go to 0, the FIFO empties, run_cnt=0, CPU FSM goes to C_IDLE, vid_overrun=0. Outputs stay 0 while reset is held.
- Reset mid-operation: the in-flight access is abandoned. No vid_valid or cpu_ack is produced for it. The CPU must re-request.
- Issue stage is registered: mem_* are driven from registers loaded at each edge. At most one access per cycle.
- Video available at an edge = FIFO non-empty OR vid_req.
- Video source is the FIFO head if non-empty, else the bypass vid_addr.
- CPU eligible = (cpu_state==C_IDLE) AND cpu_req.
- Selection at each edge:
  - Video selected if available AND (NOT CPU eligible OR run_cnt<VID_RUN_MAX).
  - Else CPU selected if eligible.
  - Else idle (mem_en=0).
- run_cnt: +1 on a video issue, saturating at VID_RUN_MAX. Cleared on any non-video cycle.
- FIFO:
  - Push vid_req unless it is bypassed (FIFO empty and video selected).
  - Pop on a video issue from the head.
  - Simultaneous push and pop keeps the count.
  - Push when full with no pop: request dropped, vid_overrun<=1.
  - vid_overrun_clr clears it. A set in the same cycle wins over the clear.
- Video order is strictly preserved. vid_valid pulses the cycle after the video mem_en cycle.
- Uncontested latency: vid_req in cycle T -> mem_en in T+1 -> vid_valid in T+2.
- CPU FSM:
  - C_IDLE -> C_ISSUED when CPU is selected; mem_en in that cycle, mem_we=cpu_we.
  - C_ISSUED -> C_ACK; cpu_ack=1 in C_ACK, rdata valid.
  - C_ACK -> C_IDLE. cpu_req is ignored during C_ISSUED and C_ACK.
  - Uncontested: cpu_req seen in T -> mem_en T+1 -> cpu_ack T+2. Next request is sampled from T+3.
- Writes also ack one cycle after issue. cpu_rdata is undefined on a write ack.
- vid_valid and cpu_ack are never both 1 in the same cycle.

Test Plan:
- Reset; RAM[0x015]=0x5A; vid_req with vid_addr=0x015 in cycle T -> mem_en=1, mem_addr=0x015 in T+1; vid_valid=1, vid_data=0x5A in T+2; no other pulses.
- CPU write 0x100<=0xA5, then a read of 0x100 -> each acks 2 cycles after the request is sampled; read cpu_rdata=0xA5; mem_we=1 only in the write issue cycle.
- vid_req and cpu_req in the same cycle T, run_cnt=0 -> video issued T+1, CPU issued T+2, vid_valid T+2, cpu_ack T+3.
- vid_req held 10 cycles with addresses 0..9, cpu_req held high (re-requesting after each ack) -> issue pattern V,V,V,V,C,V,V,V,V,C; FIFO count reaches 2; all 10 vid_valid pulses appear with data in address order 0..9; vid_overrun stays 0.
- Same as above for 15 cycles -> the third CPU slot overflows the FIFO; vid_overrun=1; exactly 14 vid_valid pulses; then pulse vid_overrun_clr -> vid_overrun=0.
- Assert reset in the C_ISSUED cycle of a CPU read -> no cpu_ack, all outputs 0; after release a new read completes normally with latency 2.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the video RAM arbiter and its clients: display fetch,
// host CPU and the single-port RAM.
interface vram_arbiter_if #(
  parameter int ADDR_W = 13
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_valid;
  logic [7:0]        vid_data;
  logic              vid_overrun;
  logic              vid_overrun_clr;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  vid_req, vid_addr, vid_overrun_clr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_rdata,
    output vid_valid, vid_data, vid_overrun,
    output cpu_ack, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vid_req, vid_addr, vid_overrun_clr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_rdata,
    input  vid_valid, vid_data, vid_overrun,
    input  cpu_ack, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: in-order display fetches take priority through a
// small FIFO, while the CPU is guaranteed a slot after a bounded run of video issues.
module vram_arbiter #(
  parameter int ADDR_W         = 13,
  parameter int VID_RUN_MAX    = 4,
  parameter int VID_FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);

  localparam int PTR_W = (VID_FIFO_DEPTH > 1) ? $clog2(VID_FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(VID_FIFO_DEPTH + 1);
  localparam int RUN_W = $clog2(VID_RUN_MAX + 1);

  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(VID_FIFO_DEPTH);
  localparam logic [RUN_W-1:0] RUN_LIMIT     = RUN_W'(VID_RUN_MAX);
  localparam logic [PTR_W-1:0] PTR_LAST      = PTR_W'(VID_FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    C_IDLE   = 2'd0,
    C_ISSUED = 2'd1,
    C_ACK    = 2'd2
  } cpu_state_t;

  cpu_state_t        cpu_state;
  logic [RUN_W-1:0]  run_cnt;

  logic [ADDR_W-1:0] fifo_mem [VID_FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  fifo_cnt;

  logic              vid_inflight;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              vid_valid_q;
  logic              vid_overrun_q;
  logic              cpu_ack_q;

  logic              fifo_empty;
  logic              fifo_full;
  logic              vid_avail;
  logic              cpu_elig;
  logic              sel_vid;
  logic              sel_cpu;
  logic              fifo_pop;
  logic              fifo_push;
  logic              fifo_drop;
  logic [ADDR_W-1:0] vid_src_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every signal gets a value before any branch so no path can infer a latch.
    vid_src_addr = bus.vid_addr;
    fifo_push    = 1'b0;
    fifo_drop    = 1'b0;

    fifo_empty = (fifo_cnt == '0);
    fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
    vid_avail  = !fifo_empty || bus.vid_req;
    cpu_elig   = (cpu_state == C_IDLE) && bus.cpu_req;

    sel_vid = vid_avail && (!cpu_elig || (run_cnt < RUN_LIMIT));
    sel_cpu = !sel_vid && cpu_elig;

    if (!fifo_empty) begin
      vid_src_addr = fifo_mem[rd_ptr];
    end

    fifo_pop = sel_vid && !fifo_empty;

    // A request that is not bypassed straight to the RAM must queue or be lost.
    if (bus.vid_req && !(fifo_empty && sel_vid)) begin
      if (fifo_full && !fifo_pop) begin
        fifo_drop = 1'b1;
      end else begin
        fifo_push = 1'b1;
      end
    end
  end

  // NOTE: storage is not reset; fifo_cnt alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= bus.vid_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: state is updated with non-blocking assignments so every line sees pre-edge values.
      cpu_state     <= C_IDLE;
      run_cnt       <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fifo_cnt      <= '0;
      vid_inflight  <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      vid_valid_q   <= 1'b0;
      vid_overrun_q <= 1'b0;
      cpu_ack_q     <= 1'b0;
    end else begin
      mem_en_q     <= sel_vid || sel_cpu;
      mem_we_q     <= sel_cpu && bus.cpu_we;
      vid_inflight <= sel_vid;
      vid_valid_q  <= vid_inflight;
      cpu_ack_q    <= (cpu_state == C_ISSUED);

      if (sel_vid) begin
        mem_addr_q <= vid_src_addr;
      end else if (sel_cpu) begin
        mem_addr_q  <= bus.cpu_addr;
        mem_wdata_q <= bus.cpu_wdata;
      end

      if (!sel_vid) begin
        run_cnt <= '0;
      end else if (run_cnt != RUN_LIMIT) begin
        run_cnt <= run_cnt + 1'b1;
      end

      if (fifo_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (fifo_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (fifo_push && !fifo_pop) begin
        fifo_cnt <= fifo_cnt + 1'b1;
      end else if (fifo_pop && !fifo_push) begin
        fifo_cnt <= fifo_cnt - 1'b1;
      end

      // A drop in the same cycle as a clear keeps the flag set.
      if (fifo_drop) begin
        vid_overrun_q <= 1'b1;
      end else if (bus.vid_overrun_clr) begin
        vid_overrun_q <= 1'b0;
      end

      case (cpu_state)
        C_IDLE:   if (sel_cpu) cpu_state <= C_ISSUED;
        C_ISSUED: cpu_state <= C_ACK;
        C_ACK:    cpu_state <= C_IDLE;
        default:  cpu_state <= C_IDLE;
      endcase
    end
  end

  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.vid_valid   = vid_valid_q;
  assign bus.vid_overrun = vid_overrun_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.vid_data    = bus.mem_rdata;
  assign bus.cpu_rdata   = bus.mem_rdata;

  a_no_double_pulse : assert property (@(posedge clk) disable iff (reset)
    !(vid_valid_q && cpu_ack_q));
  a_fifo_bound : assert property (@(posedge clk) disable iff (reset)
    fifo_cnt <= FIFO_FULL_CNT);

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios followed by random
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_vram_arbiter;

  localparam int ADDR_W  = 13;
  localparam int RUN_MAX = 4;
  localparam int DEPTH   = 2;
  localparam int RAM_N   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;

  vram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  vram_arbiter #(
    .ADDR_W        (ADDR_W),
    .VID_RUN_MAX   (RUN_MAX),
    .VID_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [ADDR_W-1:0] a);
    if (a == 13'h015) return 8'h5A;
    return 8'((a * 37) + 11);
  endfunction

  // RAM behind the arbiter: one-cycle read latency, contents start at init_val().
  logic [7:0] ram   [RAM_N];
  bit         ram_w [RAM_N];

  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we === 1'b1) begin
        ram[bus.mem_addr]   <= bus.mem_wdata;
        ram_w[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= ram_w[bus.mem_addr] ? ram[bus.mem_addr] : init_val(bus.mem_addr);
      end
    end
  end

  // Reference model state: pending video addresses as a queue, CPU phase as a number.
  int unsigned      mq[$];
  int               run_m;
  int               cph;
  bit               vpend;
  logic [7:0]       vpend_data;
  logic [7:0]       crd;
  bit               cread;
  logic [7:0]       sh    [RAM_N];
  bit               sh_w  [RAM_N];

  logic             e_mem_en, e_mem_we, e_vid_valid, e_cpu_ack, e_ovr;
  logic [ADDR_W-1:0] e_addr;
  logic [7:0]       e_wdata, e_vid_data, e_cpu_rdata;
  bit               chk_addr, chk_wdata, chk_rdata;

  int vectors     = 0;
  int miscompares = 0;
  int n_vv        = 0;

  function automatic logic [7:0] mem_val(input logic [ADDR_W-1:0] a);
    return sh_w[a] ? sh[a] : init_val(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit q_empty, q_full, avail, elig, selv, selc, pop;
    logic [ADDR_W-1:0] va;
    if (reset) begin
      mq.delete();
      run_m = 0; cph = 0; vpend = 0; cread = 0;
      e_mem_en = 0; e_mem_we = 0; e_addr = '0; e_wdata = '0;
      e_vid_valid = 0; e_cpu_ack = 0; e_ovr = 0;
      chk_addr = 1; chk_wdata = 1; chk_rdata = 0;
      return;
    end
    e_vid_valid = vpend;
    e_vid_data  = vpend_data;
    e_cpu_ack   = (cph == 1);
    chk_rdata   = (cph == 1) && cread;
    e_cpu_rdata = crd;

    q_empty = (mq.size() == 0);
    q_full  = (mq.size() == DEPTH);
    avail   = !q_empty || bus.vid_req;
    elig    = (cph == 0) && bus.cpu_req;
    selv    = avail && (!elig || run_m < RUN_MAX);
    selc    = !selv && elig;
    pop     = selv && !q_empty;

    e_mem_en  = selv || selc;
    e_mem_we  = selc && bus.cpu_we;
    chk_addr  = e_mem_en;
    chk_wdata = e_mem_we;
    vpend     = selv;

    if (selv) begin
      va = q_empty ? bus.vid_addr : ADDR_W'(mq.pop_front());
      e_addr     = va;
      vpend_data = mem_val(va);
      run_m      = (run_m < RUN_MAX) ? run_m + 1 : RUN_MAX;
    end else begin
      run_m = 0;
    end

    if (bus.vid_req && !(q_empty && selv) && q_full && !pop) begin
      e_ovr = 1;
    end else begin
      if (bus.vid_req && !(q_empty && selv)) mq.push_back(bus.vid_addr);
      if (bus.vid_overrun_clr) e_ovr = 0;
    end

    if (cph == 1) cph = 2;
    else if (cph == 2) cph = 0;
    else if (selc) begin
      cph     = 1;
      e_addr  = bus.cpu_addr;
      e_wdata = bus.cpu_wdata;
      cread   = !bus.cpu_we;
      if (bus.cpu_we) begin
        sh[bus.cpu_addr]   = bus.cpu_wdata;
        sh_w[bus.cpu_addr] = 1;
      end else begin
        crd = mem_val(bus.cpu_addr);
      end
    end
  endtask

  task automatic compare();
    check("mem_en", bus.mem_en, e_mem_en);
    check("mem_we", bus.mem_we, e_mem_we);
    if (chk_addr)  check("mem_addr", bus.mem_addr, e_addr);
    if (chk_wdata) check("mem_wdata", bus.mem_wdata, e_wdata);
    check("vid_valid", bus.vid_valid, e_vid_valid);
    if (e_vid_valid) check("vid_data", bus.vid_data, e_vid_data);
    check("cpu_ack", bus.cpu_ack, e_cpu_ack);
    if (chk_rdata) check("cpu_rdata", bus.cpu_rdata, e_cpu_rdata);
    check("vid_overrun", bus.vid_overrun, e_ovr);
    check("exclusive_pulses", bus.vid_valid & bus.cpu_ack, 1'b0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
    if (bus.vid_valid === 1'b1) n_vv++;
  endtask

  task automatic idle(input int n);
    bus.vid_req = 0; bus.cpu_req = 0; bus.vid_overrun_clr = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic held_run(input int n, input int exp_vv, input logic exp_ovr);
    string      exp_pat;
    logic [7:0] kind;
    exp_pat = "VVVVCVVVVC";
    idle(4);
    n_vv = 0;
    for (int k = 0; k < n; k++) begin
      bus.vid_req  = 1; bus.vid_addr = ADDR_W'(k);
      bus.cpu_req  = 1; bus.cpu_we = 0; bus.cpu_addr = 13'h1F00;
      cycle();
      kind = (bus.mem_en !== 1'b1) ? 8'h2D : (bus.mem_addr == 13'h1F00) ? 8'h43 : 8'h56;
      if (k < 10) check($sformatf("issue_pattern[%0d]", k), kind, exp_pat[k]);
    end
    bus.vid_req = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (bus.cpu_ack === 1'b1) bus.cpu_req = 0;
    end
    check("vid_valid_count", n_vv, exp_vv);
    check("overrun_after_run", bus.vid_overrun, exp_ovr);
  endtask

  initial begin
    reset = 1;
    bus.vid_req = 0; bus.vid_addr = '0; bus.vid_overrun_clr = 0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    cycle(); cycle(); cycle();
    check("reset_mem_en", bus.mem_en, 1'b0);
    reset = 0;
    idle(2);

    // Single uncontested fetch of RAM[0x015].
    bus.vid_req = 1; bus.vid_addr = 13'h015;
    cycle();
    check("fetch_issue_addr", bus.mem_addr, 13'h015);
    bus.vid_req = 0;
    cycle();
    check("fetch_valid", bus.vid_valid, 1'b1);
    check("fetch_data", bus.vid_data, 8'h5A);
    cycle();

    // CPU write then read-back.
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 13'h100; bus.cpu_wdata = 8'hA5;
    cycle();
    check("wr_issue_we", bus.mem_we, 1'b1);
    cycle();
    check("wr_ack", bus.cpu_ack, 1'b1);
    bus.cpu_req = 0;
    cycle();
    bus.cpu_req = 1; bus.cpu_we = 0;
    cycle();
    check("rd_issue_we", bus.mem_we, 1'b0);
    cycle();
    check("rd_ack", bus.cpu_ack, 1'b1);
    check("rd_data", bus.cpu_rdata, 8'hA5);
    bus.cpu_req = 0;
    idle(2);

    // Simultaneous video and CPU requests: video goes first.
    bus.vid_req = 1; bus.vid_addr = 13'h040;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 13'h200;
    cycle();
    check("tie_video_first", bus.mem_addr, 13'h040);
    bus.vid_req = 0;
    cycle();
    check("tie_cpu_second", bus.mem_addr, 13'h200);
    check("tie_vid_valid", bus.vid_valid, 1'b1);
    cycle();
    check("tie_cpu_ack", bus.cpu_ack, 1'b1);
    bus.cpu_req = 0;

    // Sustained video with a persistent CPU, with and without overflow.
    held_run(10, 10, 1'b0);
    held_run(15, 14, 1'b1);
    bus.vid_overrun_clr = 1;
    cycle();
    check("overrun_cleared", bus.vid_overrun, 1'b0);
    bus.vid_overrun_clr = 0;
    idle(2);

    // Reset during the issue cycle of a CPU read abandons it.
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 13'h100;
    cycle();
    check("abort_issue", bus.mem_en, 1'b1);
    reset = 1; bus.cpu_req = 0;
    cycle();
    check("abort_no_ack", bus.cpu_ack, 1'b0);
    cycle();
    check("abort_no_late_ack", bus.cpu_ack, 1'b0);
    reset = 0;
    cycle();
    bus.cpu_req = 1;
    cycle();
    cycle();
    check("post_reset_ack", bus.cpu_ack, 1'b1);
    check("post_reset_data", bus.cpu_rdata, 8'hA5);
    bus.cpu_req = 0;
    idle(2);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      reset               = ($urandom_range(0, 199) == 0);
      bus.vid_req         = ($urandom_range(0, 9) < 6);
      bus.vid_addr        = ADDR_W'($urandom_range(0, 255));
      bus.vid_overrun_clr = ($urandom_range(0, 15) == 0);
      if (reset) begin
        bus.cpu_req = 0;
      end else if (!bus.cpu_req && $urandom_range(0, 2) == 0) begin
        bus.cpu_req   = 1;
        bus.cpu_we    = $urandom_range(0, 1) == 1;
        bus.cpu_addr  = ADDR_W'($urandom_range(0, 255));
        bus.cpu_wdata = 8'($urandom);
      end
      cycle();
      if (bus.cpu_ack === 1'b1) bus.cpu_req = 0;
    end
    reset = 0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
